// File: rtl/soundweb_pkg.sv
// Shared constants, FSM state type and escape predicate for the Soundweb TX path.
// SOUNDWEB_TX_ACK_EN adds the ACK_WAIT state.
package soundweb_pkg;

   localparam logic [7:0] STX = 8'h02;
   localparam logic [7:0] ETX = 8'h03;
   localparam logic [7:0] ACK = 8'h06;
   localparam logic [7:0] NAK = 8'h15;
   localparam logic [7:0] ESC = 8'h1B;

   localparam int BODY_LEN = 13;

   typedef enum logic [3:0] {
      S_IDLE,
      S_STX,
      S_BODY,
      S_ESC2,
      S_CSUM,
      S_CSUM_ESC2,
      S_ETX,
`ifdef SOUNDWEB_TX_ACK_EN
      S_ACK_WAIT,
`endif
      S_GAP
   } state_t;

   function automatic logic is_reserved(input logic [7:0] b);
      return b inside {STX, ETX, ACK, NAK, ESC};
   endfunction

endpackage

// File: rtl/soundweb_byte_escaper.sv
// Combinational escape helper: flags framing-reserved bytes and gives the
// byte that follows ESC on the wire.
module soundweb_byte_escaper
   import soundweb_pkg::*;
(
   input  logic [7:0] din,
   output logic       needs_esc,
   output logic [7:0] dout
);

   assign needs_esc = is_reserved(din);
   assign dout      = din + 8'h80;

endmodule

// File: rtl/soundweb_tx_sequencer.sv
// Soundweb packet sequencer: frames a captured request as STX/body/checksum/ETX
// with byte stuffing. Define SOUNDWEB_TX_ACK_EN for reply wait with retry/timeout.
module soundweb_tx_sequencer
   import soundweb_pkg::*;
#(
   parameter int IFG_CYCLES  = 0,
   parameter int ACK_TIMEOUT = 100000,
   parameter int MAX_RETRY   = 3
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_i,
   input  logic [7:0]  command_i,
   input  logic [47:0] address_i,
   input  logic [15:0] sv_i,
   input  logic [31:0] data_i,
   output logic        ready_o,
   output logic [7:0]  tx_data_o,
   output logic        tx_valid_o,
   input  logic        tx_ready_i,
`ifdef SOUNDWEB_TX_ACK_EN
   input  logic [7:0]  rx_data_i,
   input  logic        rx_valid_i,
`endif
   output logic        done_o,
   output logic        err_o
);

   localparam int GW = (IFG_CYCLES > 0) ? $clog2(IFG_CYCLES + 1) : 1;

   state_t                      state_q, state_nxt;
   logic [BODY_LEN-1:0][7:0]    pkt_in, body_q;
   logic [7:0]                  csum_in, csum_q;
   logic [3:0]                  idx_q;
   logic [GW-1:0]               gap_q;
   logic [7:0]                  cur_byte, esc_byte;
   logic                        needs_esc, done_nxt, err_nxt;

   // Element 12 is the command byte, so body index k lives at [12-k].
   assign pkt_in = {command_i, address_i, sv_i, data_i};

   always_comb begin
      csum_in = '0;
      for (int i = 0; i < BODY_LEN; i++) csum_in ^= pkt_in[i];
   end

   assign cur_byte = (state_q == S_CSUM || state_q == S_CSUM_ESC2) ? csum_q
                                                                   : body_q[4'd12 - idx_q];

   soundweb_byte_escaper u_esc (
      .din       (cur_byte),
      .needs_esc (needs_esc),
      .dout      (esc_byte)
   );

   assign ready_o = (state_q == S_IDLE);

`ifdef SOUNDWEB_TX_ACK_EN
   localparam int TW  = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
   localparam int RTW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

   logic [TW-1:0]  timer_q;
   logic [RTW-1:0] retry_q;
   logic           timeout;

   assign timeout = (timer_q == TW'(ACK_TIMEOUT - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         timer_q <= '0;
         retry_q <= '0;
      end else begin
         timer_q <= (state_q == S_ACK_WAIT) ? timer_q + TW'(1) : '0;
         if (state_q == S_IDLE)
            retry_q <= '0;
         else if (state_q == S_ACK_WAIT && state_nxt == S_STX)
            retry_q <= retry_q + RTW'(1);
      end
   end
`endif

   always_comb begin
      state_nxt  = state_q;
      tx_valid_o = 1'b0;
      tx_data_o  = 8'h00;
      done_nxt   = 1'b0;
      err_nxt    = 1'b0;
      case (state_q)
         S_IDLE: if (req_i) state_nxt = S_STX;
         S_STX: begin
            tx_valid_o = 1'b1;
            tx_data_o  = STX;
            if (tx_ready_i) state_nxt = S_BODY;
         end
         S_BODY: begin
            tx_valid_o = 1'b1;
            tx_data_o  = needs_esc ? ESC : cur_byte;
            if (tx_ready_i)
               state_nxt = needs_esc ? S_ESC2 : (idx_q == 4'd12) ? S_CSUM : S_BODY;
         end
         S_ESC2: begin
            tx_valid_o = 1'b1;
            tx_data_o  = esc_byte;
            if (tx_ready_i) state_nxt = (idx_q == 4'd12) ? S_CSUM : S_BODY;
         end
         S_CSUM: begin
            tx_valid_o = 1'b1;
            tx_data_o  = needs_esc ? ESC : cur_byte;
            if (tx_ready_i) state_nxt = needs_esc ? S_CSUM_ESC2 : S_ETX;
         end
         S_CSUM_ESC2: begin
            tx_valid_o = 1'b1;
            tx_data_o  = esc_byte;
            if (tx_ready_i) state_nxt = S_ETX;
         end
         S_ETX: begin
            tx_valid_o = 1'b1;
            tx_data_o  = ETX;
            if (tx_ready_i) begin
`ifdef SOUNDWEB_TX_ACK_EN
               state_nxt = S_ACK_WAIT;
`else
               state_nxt = S_GAP;
               done_nxt  = 1'b1;
`endif
            end
         end
`ifdef SOUNDWEB_TX_ACK_EN
         S_ACK_WAIT: begin
            // An ACK in the same cycle as the timeout still counts as success.
            if (rx_valid_i && rx_data_i == ACK) begin
               state_nxt = S_GAP;
               done_nxt  = 1'b1;
            end else if ((rx_valid_i && rx_data_i == NAK) || timeout) begin
               if (retry_q < RTW'(MAX_RETRY)) begin
                  state_nxt = S_STX;
               end else begin
                  state_nxt = S_GAP;
                  done_nxt  = 1'b1;
                  err_nxt   = 1'b1;
               end
            end
         end
`endif
         S_GAP: if (gap_q == GW'(IFG_CYCLES)) state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         body_q  <= '0;
         csum_q  <= '0;
         idx_q   <= '0;
         gap_q   <= '0;
         done_o  <= 1'b0;
         err_o   <= 1'b0;
      end else begin
         state_q <= state_nxt;
         done_o  <= done_nxt;
         err_o   <= err_nxt;
         if (state_q == S_IDLE && req_i) begin
            body_q <= pkt_in;
            csum_q <= csum_in;
         end
         // Index moves only once a body byte is fully on the wire.
         if (state_q == S_STX)
            idx_q <= '0;
         else if (tx_ready_i && idx_q != 4'd12 &&
                  ((state_q == S_BODY && !needs_esc) || state_q == S_ESC2))
            idx_q <= idx_q + 4'd1;
         gap_q <= (state_q == S_GAP) ? gap_q + GW'(1) : '0;
      end
   end

endmodule

// File: tb/tb_soundweb_tx_sequencer.sv
// Directed bench for soundweb_tx_sequencer with a byte scoreboard.
module tb_soundweb_tx_sequencer;

   localparam int IFG = 3;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_i = 1'b0;
   logic [7:0]  command_i = '0;
   logic [47:0] address_i = '0;
   logic [15:0] sv_i = '0;
   logic [31:0] data_i = '0;
   logic        tx_ready_i = 1'b0;
   logic        ready_o, tx_valid_o, done_o, err_o;
   logic [7:0]  tx_data_o;
`ifdef SOUNDWEB_TX_ACK_EN
   logic [7:0]  rx_data_i = '0;
   logic        rx_valid_i = 1'b0;
   logic [7:0]  rply_q[$];
`endif

   int total = 0;
   int bad = 0;
   logic [7:0] exp_q[$];

   soundweb_tx_sequencer #(.IFG_CYCLES(IFG), .ACK_TIMEOUT(40), .MAX_RETRY(1)) dut (
      .clk        (clk),
      .rst        (rst),
      .req_i      (req_i),
      .command_i  (command_i),
      .address_i  (address_i),
      .sv_i       (sv_i),
      .data_i     (data_i),
      .ready_o    (ready_o),
      .tx_data_o  (tx_data_o),
      .tx_valid_o (tx_valid_o),
      .tx_ready_i (tx_ready_i),
`ifdef SOUNDWEB_TX_ACK_EN
      .rx_data_i  (rx_data_i),
      .rx_valid_i (rx_valid_i),
`endif
      .done_o     (done_o),
      .err_o      (err_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic push_esc(input logic [7:0] b);
      if (b == 8'h02 || b == 8'h03 || b == 8'h06 || b == 8'h15 || b == 8'h1B) begin
         exp_q.push_back(8'h1B);
         exp_q.push_back(b + 8'h80);
      end else begin
         exp_q.push_back(b);
      end
   endtask

   // Reference framing: STX, stuffed body, stuffed XOR checksum, ETX.
   task automatic push_pkt(input logic [7:0] cmd, input logic [47:0] a, input logic [15:0] s,
                           input logic [31:0] d, output int len);
      logic [7:0] b[13];
      logic [7:0] x;
      int n0;
      n0 = exp_q.size();
      b[0] = cmd;
      for (int i = 0; i < 6; i++) b[1+i] = a[47-8*i -: 8];
      for (int i = 0; i < 2; i++) b[7+i] = s[15-8*i -: 8];
      for (int i = 0; i < 4; i++) b[9+i] = d[31-8*i -: 8];
      x = 8'h00;
      exp_q.push_back(8'h02);
      for (int i = 0; i < 13; i++) begin
         x ^= b[i];
         push_esc(b[i]);
      end
      push_esc(x);
      exp_q.push_back(8'h03);
      len = exp_q.size() - n0;
   endtask

   task automatic send(input logic [7:0] cmd, input logic [47:0] a, input logic [15:0] s,
                       input logic [31:0] d);
      for (int i = 0; i < 50 && !ready_o; i++) @(negedge clk);
      chk("ready_before_req", 32'(ready_o), 32'd1);
      req_i = 1'b1;
      command_i = cmd; address_i = a; sv_i = s; data_i = d;
      @(negedge clk);
      req_i = 1'b0;
      command_i = ~cmd; address_i = ~a; sv_i = ~s; data_i = ~d;
      chk("ready_after_accept", 32'(ready_o), 32'd0);
      chk("valid_after_accept", 32'(tx_valid_o), 32'd1);
   endtask

   // mode 0: always ready; 1: 5-cycle stall after each ESC; 2: random ready + req noise.
   task automatic drain(input int mode, input bit exp_err, input int exp_bytes, input int abort_at);
      int bytes = 0, stall = 0, gap = 0;
      bit got_done = 0, aborted = 0, pv = 0, pr = 0;
      logic [7:0] pd = '0, e;
      for (int cyc = 0; cyc < 600; cyc++) begin
         if (pv && !pr) begin
            chk("stall_valid_held", 32'(tx_valid_o), 32'd1);
            chk("stall_data_stable", 32'(tx_data_o), 32'(pd));
         end
         if (done_o) begin
            got_done = 1;
            req_i = 1'b0;
            break;
         end
         case (mode)
            1: if (stall > 0) begin tx_ready_i = 1'b0; stall--; end else tx_ready_i = 1'b1;
            2: begin
               tx_ready_i = 1'($urandom_range(0, 1));
               req_i = 1'($urandom_range(0, 1));
            end
            default: tx_ready_i = 1'b1;
         endcase
`ifdef SOUNDWEB_TX_ACK_EN
         rx_valid_i = 1'b0;
         if (!tx_valid_o && bytes > 0 && rply_q.size() > 0) begin
            rx_valid_i = 1'b1;
            rx_data_i = rply_q.pop_front();
         end
`endif
         if (tx_valid_o && tx_ready_i) begin
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
            chk("tx_byte", 32'(tx_data_o), 32'(e));
            bytes++;
            if (mode == 1 && tx_data_o == 8'h1B) stall = 5;
            if (bytes == abort_at) begin
               rst = 1'b1;
               #1;
               chk("abort_valid", 32'(tx_valid_o), 32'd0);
               chk("abort_ready", 32'(ready_o), 32'd1);
               chk("abort_data", 32'(tx_data_o), 32'd0);
               aborted = 1;
               break;
            end
         end
         pv = tx_valid_o; pr = tx_ready_i; pd = tx_data_o;
         @(negedge clk);
      end
      req_i = 1'b0;
      if (!aborted) begin
         chk("done_seen", 32'(got_done), 32'd1);
         chk("done_err", 32'(err_o), 32'(exp_err));
         chk("byte_count", 32'(bytes), 32'(exp_bytes));
         chk("queue_empty", 32'(exp_q.size()), 32'd0);
         tx_ready_i = 1'b0;
         for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (ready_o) break;
            gap++;
         end
         chk("gap_cycles", 32'(gap), 32'(IFG));
      end
   endtask

   function automatic logic [7:0] pick();
      case ($urandom_range(0, 6))
         0: return 8'h02;
         1: return 8'h03;
         2: return 8'h06;
         3: return 8'h15;
         4: return 8'h1B;
         5: return 8'h00;
         default: return 8'($urandom);
      endcase
   endfunction

   initial begin
      int len, ndone;
      logic [7:0] c;
      logic [47:0] a;
      logic [15:0] s;
      logic [31:0] d;

      repeat (2) @(negedge clk);
      chk("rst_ready", 32'(ready_o), 32'd1);
      chk("rst_valid", 32'(tx_valid_o), 32'd0);
      chk("rst_data", 32'(tx_data_o), 32'd0);
      chk("rst_done", 32'(done_o), 32'd0);
      chk("rst_err", 32'(err_o), 32'd0);
      rst = 1'b0;
      @(negedge clk);

      // Reference packet with an escaped address byte.
      push_pkt(8'h88, 48'h000103000100, 16'h0000, 32'h00000001, len);
      chk("len_ref", 32'(len), 32'd17);
      send(8'h88, 48'h000103000100, 16'h0000, 32'h00000001);
      drain(0, 1'b0, len, 0);

      // Escaped command and escaped checksum.
      push_pkt(8'h02, 48'h0, 16'h0, 32'h0, len);
      chk("len_cmd02", 32'(len), 32'd18);
      send(8'h02, 48'h0, 16'h0, 32'h0);
      drain(0, 1'b0, len, 0);

      // Stall on the second byte of an escape pair.
      push_pkt(8'h88, 48'h000103000100, 16'h0000, 32'h00000001, len);
      send(8'h88, 48'h000103000100, 16'h0000, 32'h00000001);
      drain(1, 1'b0, len, 0);

      // Reset mid-packet, then a clean packet.
      push_pkt(8'h88, 48'h000103000100, 16'h0000, 32'h00000001, len);
      send(8'h88, 48'h000103000100, 16'h0000, 32'h00000001);
      drain(0, 1'b0, len, 7);
      @(negedge clk);
      rst = 1'b0;
      exp_q.delete();
      ndone = 0;
      for (int i = 0; i < 10; i++) begin
         ndone += int'(done_o);
         @(negedge clk);
      end
      chk("no_done_after_abort", 32'(ndone), 32'd0);
      push_pkt(8'h41, 48'h1B0215060300, 16'h1503, 32'hDEADBEEF, len);
      send(8'h41, 48'h1B0215060300, 16'h1503, 32'hDEADBEEF);
      drain(0, 1'b0, len, 0);

      // Random fields biased to reserved values, random back-pressure.
      for (int k = 0; k < 5; k++) begin
         c = pick();
         for (int i = 0; i < 6; i++) a[47-8*i -: 8] = pick();
         for (int i = 0; i < 2; i++) s[15-8*i -: 8] = pick();
         for (int i = 0; i < 4; i++) d[31-8*i -: 8] = pick();
         push_pkt(c, a, s, d, len);
         chk("len_range", 32'(len >= 16 && len <= 30), 32'd1);
         send(c, a, s, d);
         drain(2, 1'b0, len, 0);
      end

`ifdef SOUNDWEB_TX_ACK_EN
      // Ignored byte, NAK, then ACK: two copies, success.
      push_pkt(8'h88, 48'h000103000100, 16'h0000, 32'h00000001, len);
      push_pkt(8'h88, 48'h000103000100, 16'h0000, 32'h00000001, len);
      rply_q = {8'h55, 8'h15, 8'h06};
      send(8'h88, 48'h000103000100, 16'h0000, 32'h00000001);
      drain(0, 1'b0, 2 * len, 0);
      // Silence: two timeouts, failure.
      push_pkt(8'h10, 48'h1, 16'h2, 32'h3, len);
      push_pkt(8'h10, 48'h1, 16'h2, 32'h3, len);
      rply_q.delete();
      send(8'h10, 48'h1, 16'h2, 32'h3);
      drain(0, 1'b1, 2 * len, 0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/soundweb_tx_sequencer.md
SOUNDWEB_TX_SEQUENCER -- requirements
Module: soundweb_tx_sequencer

Interface
REQ-001 Parameter IFG_CYCLES, default 0, idle cycles inserted after each packet before ready_o reasserts.
REQ-002 Parameter ACK_TIMEOUT, default 100000, cycles to wait for a reply (SOUNDWEB_TX_ACK_EN only).
REQ-003 Parameter MAX_RETRY, default 3, retransmissions allowed after NAK or timeout (SOUNDWEB_TX_ACK_EN only).
REQ-004 One clock and one reset; reset is asynchronous and active-high.
REQ-005 clk  in  1  rising-edge clock for all state.
REQ-006 rst  in  1  asynchronous active-high reset.
REQ-007 req_i  in  1  packet request; accepted when req_i & ready_o.
REQ-008 command_i  in  8, address_i  in  48 (byte 0 = [47:40]), sv_i  in  16 ([15:8] first), data_i  in  32 ([31:24] first); captured on accept.
REQ-009 ready_o  out  1  sequencer idle and able to accept a request.
REQ-010 tx_data_o  out  8, tx_valid_o  out  1, tx_ready_i  in  1  byte stream to the UART; a byte transfers when tx_valid_o & tx_ready_i.
REQ-011 done_o  out  1  one-cycle pulse at packet completion; err_o  out  1  qualifies done_o (1 = failed).

Function
REQ-012 Wire format: STX 0x02, 13 body bytes (command, address 0..5, sv 0..1, data 0..3), checksum, ETX 0x03.
REQ-013 Checksum is the XOR of the 13 unescaped body bytes.
REQ-014 Body and checksum bytes equal to 0x02, 0x03, 0x06, 0x15 or 0x1B are sent as 0x1B then (byte + 0x80) mod 256; STX and ETX are never escaped.
REQ-015 States: IDLE, STX, BODY, ESC2, CSUM, CSUM_ESC2, ETX, ACK_WAIT (SOUNDWEB_TX_ACK_EN only), GAP.
REQ-016 Transitions: accept in IDLE -> STX; after STX -> BODY; an escaped byte -> ESC2 -> BODY; after body index 12 -> CSUM (-> CSUM_ESC2 when escaped) -> ETX; after ETX -> ACK_WAIT or GAP; GAP -> IDLE after IFG_CYCLES cycles (0 = immediately).
REQ-017 A 4-bit body index counts 0..12 and advances only on a handshake of an unescaped byte or of an ESC2 byte.
REQ-018 tx_valid_o asserts the cycle after accept and stays high until the ETX handshake; the next byte appears the cycle after each handshake, with no bubbles.
REQ-019 tx_data_o is stable while tx_valid_o & !tx_ready_i.
REQ-020 ready_o is high only in IDLE; req_i outside IDLE is ignored, and inputs are not sampled after accept.
REQ-021 Without ACK, done_o pulses with err_o=0 in the cycle after the ETX handshake.
REQ-022 Packet length is 16..30 bytes.

Reset
REQ-023 On rst: state IDLE, ready_o=1, tx_valid_o=0, tx_data_o=0x00, done_o=0, err_o=0, counters and checksum cleared.
REQ-024 Reset asserted mid-packet aborts the packet immediately; no done_o is produced.

Configuration
REQ-025 Macro SOUNDWEB_TX_ACK_EN adds ports rx_data_i (in 8) and rx_valid_i (in 1) and state ACK_WAIT.
REQ-026 With SOUNDWEB_TX_ACK_EN: in ACK_WAIT, rx 0x06 -> done_o with err_o=0; rx 0x15 or ACK_TIMEOUT elapsed -> resend the same captured packet from STX if retries < MAX_RETRY, else done_o with err_o=1; other rx bytes are ignored; then GAP.
REQ-027 Without SOUNDWEB_TX_ACK_EN: ETX leads directly to GAP; the rx ports, retry logic and timeout logic do not exist.

Structure
REQ-028 Package soundweb_pkg holds STX, ETX, ACK, NAK and ESC constants, the state enum typedef, and the is_reserved function.
REQ-029 One sub-module, soundweb_byte_escaper (combinational): byte in -> needs_esc, escaped byte out; instantiated once on the current byte.

Verification
REQ-030 cmd 0x88, addr 00 01 03 00 01 00, sv 0000, data 00000001, tx_ready_i=1 -> 02 88 00 01 1B 83 00 01 00 00 00 00 00 00 01 8A 03 (17 bytes), done_o with err_o=0.
REQ-031 cmd 0x02, all other fields 0 -> 02 1B 82 followed by twelve 00, then 1B 82 03 (checksum 0x02 escaped), 18 bytes.
REQ-032 Hold tx_ready_i low 5 cycles on the ESC2 byte -> tx_data_o=0x83 is stable and no byte is skipped or duplicated.
REQ-033 rst pulsed at byte 7 -> tx_valid_o=0 immediately, ready_o=1, no done_o; the next request sends a complete correct packet.
REQ-034 SOUNDWEB_TX_ACK_EN, MAX_RETRY=1: reply NAK then 0x06 -> packet sent twice, done_o err_o=0; no reply at all -> two timeouts, then done_o err_o=1.
REQ-035 IFG_CYCLES=3 with back-to-back requests -> ready_o is low for exactly 3 cycles after the done cycle.
